regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: A (ALU pipe) and B (load unit).
- Fixed priority to A, with a starvation guard that forces a grant to B after MAX_WAIT consecutive blocked cycles.
- Registers the winning request onto the write port (we/rw/wdata) one cycle after acceptance.
- Optionally drops writes to register 0 so x0 stays zero.

Parameters:
ADDR_WIDTH, 5, register address width; must match the register file.
DATA_WIDTH, 32, write data width.
MAX_WAIT, 3, consecutive cycles B may be blocked before it is forced through; must be ≥1.
ZERO_REG, 1, when 1, accepted writes to address 0 are consumed but never asserted on we_o.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
a_valid_i  in  1  source A write request
a_addr_i  in  ADDR_WIDTH  source A destination register
a_data_i  in  DATA_WIDTH  source A write data
a_ready_o  out  1  source A accepted this cycle when a_valid_i & a_ready_o
b_valid_i  in  1  source B write request
b_addr_i  in  ADDR_WIDTH  source B destination register
b_data_i  in  DATA_WIDTH  source B write data
b_ready_o  out  1  source B accepted this cycle when b_valid_i & b_ready_o
we_o  out  1  register file write enable (registered)
rw_o  out  ADDR_WIDTH  register file write address (registered)
wdata_o  out  DATA_WIDTH  register file write data (registered)
grant_b_o  out  1  registered; 1 if the write currently on the port came from B
starved_o  out  1  combinational; B is in forced-grant condition

Behaviour:
- Reset (rst_ni=0, asynchronous): we_o=0, rw_o=0, wdata_o=0, grant_b_o=0, wait counter=0. starved_o=0 follows from counter=0.
- Ready logic is combinational from valids and the counter. Priority:
  - starved = (wait_cnt == MAX_WAIT); starved_o = starved.
  - a_ready_o = !(starved & b_valid_i).
  - b_ready_o = !a_valid_i | starved.
  - a_ready_o and b_ready_o are never both 1 while both valids are 1.
  - A ready never depends on a_valid_i; B ready never depends on b_valid_i.
- Acceptance and latency:
  - One transfer per cycle at most.
  - At the edge after acceptance of source S: rw_o=S.addr, wdata_o=S.data, grant_b_o=(S==B).
  - we_o=1 unless ZERO_REG=1 and S.addr==0, in which case we_o=0.
  - With no acceptance: we_o=0 next cycle; rw_o and wdata_o hold their last values.
  - Write latency is 1 cycle from acceptance to we_o.
  - The register file commits on the following edge, so data is visible to reads 2 edges after acceptance.
- Wait counter (width clog2(MAX_WAIT+1)), priority order:
  1. b_valid_i & b_ready_o → 0.
  2. Else b_valid_i & !b_ready_o → increment, saturate at MAX_WAIT.
  3. Else (b_valid_i=0) → 0.
- Starvation sequence: B blocked for MAX_WAIT cycles → next cycle starved=1 → B granted, A stalled for exactly that cycle → counter clears. In steady contention B wins 1 of every MAX_WAIT+1 cycles.
- Sources must hold valid, addr and data stable until accepted. The arbiter does not check this.
- Same-address writes from A and B in consecutive cycles commit in acceptance order; the later one wins.
- Reset mid-contention: counter clears, any pending registered write is dropped (we_o=0), and A priority resumes on release.
- No internal buffering: a dropped valid before acceptance is simply never written.

Test Plan:
- Reset: assert rst_ni=0 mid-cycle with we_o=1 → we_o, rw_o, wdata_o, grant_b_o immediately 0; counter 0.
- A alone: a_valid_i=1, addr=5, data=0xDEADBEEF → a_ready_o=1; next cycle we_o=1, rw_o=5, wdata_o=0xDEADBEEF, grant_b_o=0.
- B alone: b_valid_i=1, addr=7, data=0x12345678, a_valid_i=0 → b_ready_o=1; next cycle we_o=1, rw_o=7, grant_b_o=1.
- Starvation (MAX_WAIT=3): A and B valid continuously →
  - cycles 0-2 grant A (b_ready_o=0, counter 1,2,3);
  - cycle 3 starved_o=1, a_ready_o=0, b_ready_o=1;
  - cycle 4 grant A again;
  - pattern A,A,A,B repeats and we_o stays 1 every cycle.
- x0 suppression (ZERO_REG=1): A writes addr 0 data 0xFFFFFFFF → a_ready_o=1, next cycle we_o=0. With ZERO_REG=0 → we_o=1, rw_o=0.
- Back-to-back same address: A addr 3 data 1, then B addr 3 data 2 with A idle → we_o high two consecutive cycles; a read of x3 returns 2.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources (A = ALU pipe, B = load
// unit) and the register-file write port.
//
// Handshake: a source holds valid/addr/data stable until accepted; a transfer
// happens in the cycle where valid and ready are both 1. Ready is a function
// of the other side's request only, never of the source's own valid.
//
// The master modport is the source/register-file side. The slave modport is
// the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // Source A (ALU pipe) request channel
    logic                  a_valid_i;
    logic [ADDR_WIDTH-1:0] a_addr_i;
    logic [DATA_WIDTH-1:0] a_data_i;
    logic                  a_ready_o;

    // Source B (load unit) request channel
    logic                  b_valid_i;
    logic [ADDR_WIDTH-1:0] b_addr_i;
    logic [DATA_WIDTH-1:0] b_data_i;
    logic                  b_ready_o;

    // Registered register-file write port
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] rw_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic                  grant_b_o;

    // Live view of the starvation guard
    logic                  starved_o;

    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        input  a_ready_o, b_ready_o,
        input  we_o, rw_o, wdata_o, grant_b_o, starved_o
    );

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        output a_ready_o, b_ready_o,
        output we_o, rw_o, wdata_o, grant_b_o, starved_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port.
//
// Source A has fixed priority. Source B counts consecutive blocked cycles.
// Once that count reaches MAX_WAIT, B is forced through for one cycle and
// A is stalled. Under steady contention, B therefore wins 1 of every
// MAX_WAIT+1 cycles.
//
// The winning request is registered onto we/rw/wdata one cycle after
// acceptance. With ZERO_REG=1, writes to x0 are still accepted and consumed
// but never raise we_o, so x0 reads as zero.
//
// MAX_WAIT must be at least 1.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WAIT);

    // Starvation bookkeeping for B
    logic [CNT_W-1:0]      wait_cnt;
    logic [CNT_W-1:0]      wait_cnt_next;
    logic                  starved;

    // Handshake decode
    logic                  a_ready;
    logic                  b_ready;
    logic                  a_accept;
    logic                  b_accept;
    logic                  accept;

    // Selected request heading for the write port
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  drop_zero;

    // Registered write port
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] rw_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  grant_b_q;

    // Ready generation.
    // A is ready unless B is starved and asking.
    // B is ready when A is idle, or when B is starved.
    // Each ready looks only at the other side's valid, so at most one source
    // is accepted per cycle.
    always_comb begin
        starved  = (wait_cnt == MAX_CNT);
        a_ready  = !(starved && bus.b_valid_i);
        b_ready  = !bus.a_valid_i || starved;
        a_accept = bus.a_valid_i && a_ready;
        b_accept = bus.b_valid_i && b_ready;
        accept   = a_accept || b_accept;
    end

    // Select the accepted request, and flag x0 writes that must not reach we_o
    always_comb begin
        sel_addr = bus.a_addr_i;
        sel_data = bus.a_data_i;
        if (b_accept) begin
            sel_addr = bus.b_addr_i;
            sel_data = bus.b_data_i;
        end
        drop_zero = (ZERO_REG != 0) && (sel_addr == '0);
    end

    // Next wait count.
    // A served B clears it, a blocked B counts up and saturates,
    // and an idle B clears it.
    always_comb begin
        wait_cnt_next = wait_cnt;
        if (b_accept) begin
            wait_cnt_next = '0;
        end else if (bus.b_valid_i) begin
            if (wait_cnt != MAX_CNT) begin
                wait_cnt_next = wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt_next = '0;
        end
    end

    // Wait counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end

    // Write-port register.
    // we pulses for one cycle per accepted, non-dropped write.
    // Address, data and grant source hold their values between writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q      <= 1'b0;
            rw_q      <= '0;
            wdata_q   <= '0;
            grant_b_q <= 1'b0;
        end else begin
            we_q <= accept && !drop_zero;
            if (accept) begin
                rw_q      <= sel_addr;
                wdata_q   <= sel_data;
                grant_b_q <= b_accept;
            end
        end
    end

    assign bus.a_ready_o = a_ready;
    assign bus.b_ready_o = b_ready;
    assign bus.starved_o = starved;
    assign bus.we_o      = we_q;
    assign bus.rw_o      = rw_q;
    assign bus.wdata_o   = wdata_q;
    assign bus.grant_b_o = grant_b_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (MAX_WAIT=3).
// A second instance with ZERO_REG=0 shares the same stimulus so both x0
// behaviours can be compared.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int EW = 3 + AW + DW;   // {chk, we, grant_b, rw, wdata}

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_nz ();

    regfile_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(3), .ZERO_REG(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    regfile_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(3), .ZERO_REG(0)
    ) dut_nz (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_nz)
    );

    assign bus_nz.a_valid_i = bus.a_valid_i;
    assign bus_nz.a_addr_i  = bus.a_addr_i;
    assign bus_nz.a_data_i  = bus.a_data_i;
    assign bus_nz.b_valid_i = bus.b_valid_i;
    assign bus_nz.b_addr_i  = bus.b_addr_i;
    assign bus_nz.b_data_i  = bus.b_data_i;

    // Register file stand-in: commits the write port on the next edge
    logic [DW-1:0] rf [32];
    always @(posedge clk) begin
        if (bus.we_o) rf[bus.rw_o] <= bus.wdata_o;
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle of stimulus.
    // Readies and starved are checked mid-cycle. The expected write for the
    // next edge is queued, then popped and compared just after that edge.
    // src: 0 = nothing accepted, 1 = A accepted, 2 = B accepted.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic exp_ar, input logic exp_br, input logic exp_st,
                        input int src, input string tag);
        logic [EW-1:0] e;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bus.a_valid_i = av;
        bus.a_addr_i  = aa;
        bus.a_data_i  = ad;
        bus.b_valid_i = bv;
        bus.b_addr_i  = ba;
        bus.b_data_i  = bd;
        #2;
        check({tag, "_a_ready"}, 64'(bus.a_ready_o), 64'(exp_ar));
        check({tag, "_b_ready"}, 64'(bus.b_ready_o), 64'(exp_br));
        check({tag, "_starved"}, 64'(bus.starved_o), 64'(exp_st));
        ea = (src == 2) ? ba : aa;
        ed = (src == 2) ? bd : ad;
        exp_q.push_back({(src != 0), ((src != 0) && (ea != '0)), (src == 2), ea, ed});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_we"}, 64'(bus.we_o), 64'(e[EW-2]));
            if (e[EW-1]) begin
                check({tag, "_grant_b"}, 64'(bus.grant_b_o), 64'(e[EW-3]));
                check({tag, "_rw"},      64'(bus.rw_o),      64'(e[AW+DW-1:DW]));
                check({tag, "_wdata"},   64'(bus.wdata_o),   64'(e[DW-1:0]));
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle.
    // Outputs must clear at once, and any queued write is dropped.
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_we"},      64'(bus.we_o),      64'(0));
        check({tag, "_rw"},      64'(bus.rw_o),      64'(0));
        check({tag, "_wdata"},   64'(bus.wdata_o),   64'(0));
        check({tag, "_grant_b"}, 64'(bus.grant_b_o), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a_idx;
        int b_idx;
        logic s;

        rst_n = 1'b0;
        bus.a_valid_i = 1'b0; bus.a_addr_i = '0; bus.a_data_i = '0;
        bus.b_valid_i = 1'b0; bus.b_addr_i = '0; bus.b_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",      64'(bus.we_o),      64'(0));
        check("rst_rw",      64'(bus.rw_o),      64'(0));
        check("rst_wdata",   64'(bus.wdata_o),   64'(0));
        check("rst_grant_b", 64'(bus.grant_b_o), 64'(0));
        check("rst_starved", 64'(bus.starved_o), 64'(0));
        rst_n = 1'b1;

        // A alone
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 0, 1, "a_alone");
        // B alone
        step(0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678, 1, 1, 0, 2, "b_alone");
        // idle: we drops
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 0, "idle0");

        // x0 write: dropped with ZERO_REG=1, written with ZERO_REG=0
        step(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 0, 0, 1, "x0");
        check("x0_nz_we", 64'(bus_nz.we_o), 64'(1));
        check("x0_nz_rw", 64'(bus_nz.rw_o), 64'(0));

        // back-to-back same address: A then B; the later write must win
        step(1, 5'd3, 32'd1, 0, 5'd0, 32'h0, 1, 0, 0, 1, "b2b_a");
        step(0, 5'd0, 32'h0, 1, 5'd3, 32'd2, 1, 1, 0, 2, "b2b_b");
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 0, "b2b_idle");
        check("b2b_rf_x3", 64'(rf[3]), 64'(2));

        // steady contention: A,A,A,B repeated twice
        a_idx = 0;
        b_idx = 0;
        for (int i = 0; i < 8; i++) begin
            s = ((i % 4) == 3);
            step(1, 5'(10 + a_idx), 32'hA000_0000 + 32'(a_idx),
                 1, 5'd9, 32'hB000_0000 + 32'(b_idx),
                 !s, s, s, s ? 2 : 1, "starve");
            if (s) b_idx++;
            else   a_idx++;
        end

        // reset mid-contention: counter clears, and A priority resumes with a full wait
        step(1, 5'd20, 32'hC0DE_0001, 1, 5'd21, 32'hC0DE_00B0, 1, 0, 0, 1, "pre_rst0");
        step(1, 5'd22, 32'hC0DE_0002, 1, 5'd21, 32'hC0DE_00B0, 1, 0, 0, 1, "pre_rst1");
        mid_reset("mid_rst");
        for (int i = 0; i < 4; i++) begin
            s = (i == 3);
            step(1, 5'(24 + i), 32'hD000_0000 + 32'(i), 1, 5'd21, 32'hC0DE_00B0,
                 !s, s, s, s ? 2 : 1, "post_rst");
        end
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 0, "idle_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
